// File: rtl/codec_pkg.sv
// Shared definitions for the codec-side audio blocks: default sample width
// and the receiver FSM state encoding.
package codec_pkg;

  localparam int CODEC_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2s_receiver_if.sv
// Bundle of the I2S codec pins and the sample output bus of i2s_receiver.
// The receiver uses the slave view; codec model plus sample consumer use master.
interface i2s_receiver_if
  import codec_pkg::*;
#(
  parameter int DATA_WIDTH = CODEC_DATA_WIDTH
);
  logic                  i_bclk;
  logic                  i_lrclk;
  logic                  i_sdata;
  logic                  o_audio_valid;
  logic [DATA_WIDTH-1:0] o_audio_data;
  logic                  o_frame_error;

  modport slave (
    input  i_bclk, i_lrclk, i_sdata,
    output o_audio_valid, o_audio_data, o_frame_error
  );

  modport master (
    output i_bclk, i_lrclk, i_sdata,
    input  o_audio_valid, o_audio_data, o_frame_error
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous single-bit input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SDATA on clk, deserializes one
// DATA_WIDTH-bit word per slot and forwards the word of the selected channel.
module i2s_receiver
  import codec_pkg::*;
#(
  parameter int DATA_WIDTH = CODEC_DATA_WIDTH,
  parameter bit CHANNEL    = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  i2s_receiver_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic bclk_s, lr_s, sd_s;

  sync_2ff u_sync_bclk (.clk(clk), .reset(reset), .d_i(bus.i_bclk),  .q_o(bclk_s));
  sync_2ff u_sync_lr   (.clk(clk), .reset(reset), .d_i(bus.i_lrclk), .q_o(lr_s));
  sync_2ff u_sync_sd   (.clk(clk), .reset(reset), .d_i(bus.i_sdata), .q_o(sd_s));

  rx_state_t             state_q, state_d;
  logic                  bclk_prev_q;
  logic                  lr_prev_q;
  logic                  chan_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;

  logic                  bit_evt;
  logic                  slot_start;
  logic                  shift_evt;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] shift_next;

  assign bit_evt    = bclk_s & ~bclk_prev_q;
  assign slot_start = bit_evt & (lr_s != lr_prev_q);
  assign shift_evt  = bit_evt & ~slot_start;
  assign last_bit   = (cnt_q == CW'(DATA_WIDTH - 1));
  assign shift_next = {shreg_q[DATA_WIDTH-2:0], sd_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:  if (slot_start) state_d = ST_SHIFT;
      ST_SHIFT: if (shift_evt && last_bit) state_d = ST_WAIT;
      ST_WAIT:  if (slot_start) state_d = ST_SHIFT;
      default:  state_d = ST_SYNC;
    endcase
  end

  // A slot start inside SHIFT always precedes the last bit, so valid and error are exclusive.
  always_comb begin
    valid_d = (state_q == ST_SHIFT) && shift_evt && last_bit && (chan_q == CHANNEL);
    ferr_d  = (state_q == ST_SHIFT) && slot_start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      chan_q      <= 1'b0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_s;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      if (bit_evt) lr_prev_q <= lr_s;
      if (slot_start) begin
        // The delay bit of the new slot is discarded; any partial word is dropped.
        cnt_q   <= '0;
        shreg_q <= '0;
        chan_q  <= lr_s;
      end else if (shift_evt && (state_q == ST_SHIFT)) begin
        cnt_q   <= cnt_q + CW'(1);
        shreg_q <= shift_next;
      end
      if (valid_d) data_q <= shift_next;
    end
  end

  assign bus.o_audio_valid = valid_q;
  assign bus.o_audio_data  = data_q;
  assign bus.o_frame_error = ferr_q;
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench: one codec stream drives a left-channel and a right-channel receiver.
`timescale 1ns/1ps
module tb_i2s_receiver;
  localparam int DW    = 24;
  localparam int HALF  = 160;
  localparam int BIT_T = 2 * HALF;

  logic clk = 1'b0;
  logic reset;
  logic bclk, lrclk, sdata;

  always #10 clk = ~clk;

  i2s_receiver_if #(.DATA_WIDTH(DW)) bus0 ();
  i2s_receiver_if #(.DATA_WIDTH(DW)) bus1 ();

  assign bus0.i_bclk  = bclk;
  assign bus0.i_lrclk = lrclk;
  assign bus0.i_sdata = sdata;
  assign bus1.i_bclk  = bclk;
  assign bus1.i_lrclk = lrclk;
  assign bus1.i_sdata = sdata;

  i2s_receiver #(.DATA_WIDTH(DW), .CHANNEL(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  i2s_receiver #(.DATA_WIDTH(DW), .CHANNEL(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_chk = 0;
  int n_bad = 0;

  int v0 = 0, v1 = 0, e0 = 0, e1 = 0, ovl = 0;
  longint t1_last = 0, t1_prev = 0;

  always @(negedge clk) begin
    if (bus0.o_audio_valid) v0++;
    if (bus0.o_frame_error) e0++;
    if (bus1.o_frame_error) e1++;
    if (bus1.o_audio_valid) begin
      v1++;
      t1_prev = t1_last;
      t1_last = $time;
    end
    if ((bus0.o_audio_valid && bus0.o_frame_error) || (bus1.o_audio_valid && bus1.o_frame_error))
      ovl++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit 0 carries the new LRCLK (delay bit); bits 1..DW carry the word MSB first.
  task automatic send_slot(input bit ch, input logic [DW-1:0] d, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      bclk  = 1'b0;
      lrclk = ch;
      sdata = (k >= 1 && k <= DW) ? d[DW-k] : 1'b0;
      #HALF;
      bclk = 1'b1;
      #HALF;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  int b0, b1, be0, be1;

  initial begin
    reset = 1'b1;
    bclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    #45;
    chk("rst_valid0", bus0.o_audio_valid, 0);
    chk("rst_data0",  bus0.o_audio_data,  0);
    chk("rst_ferr0",  bus0.o_frame_error, 0);
    chk("rst_data1",  bus1.o_audio_data,  0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #(BIT_T);

    // Four back-to-back frames after one right slot to establish sync.
    send_slot(1'b1, 24'h000000, 32);
    b0 = v0; b1 = v1; be0 = e0;
    repeat (4) send_frame(24'hABCDEF, 24'h123456);
    chk("frm_pulses0", v0 - b0, 4);
    chk("frm_data0",   bus0.o_audio_data, 24'hABCDEF);
    chk("frm_ferr0",   e0 - be0, 0);
    chk("frm_pulses1", v1 - b1, 4);
    chk("frm_data1",   bus1.o_audio_data, 24'h123456);
    chk("frm_spacing", t1_last - t1_prev, 64 * BIT_T);

    // Full-scale extremes pass through bit-exact.
    send_frame(24'h800000, 24'h000001);
    chk("neg_full0", bus0.o_audio_data, 24'h800000);
    chk("right_one", bus1.o_audio_data, 24'h000001);
    send_frame(24'h7FFFFF, 24'hFFFFFE);
    chk("pos_full0", bus0.o_audio_data, 24'h7FFFFF);

    // Truncated 16-bit left slot followed by an LRCLK toggle.
    b0 = v0; be0 = e0; be1 = e1;
    send_slot(1'b0, 24'h111111, 16);
    send_slot(1'b1, 24'h00FF00, 32);
    chk("short_err0",   e0 - be0, 1);
    chk("short_err1",   e1 - be1, 1);
    chk("short_novld0", v0 - b0, 0);
    chk("short_hold0",  bus0.o_audio_data, 24'h7FFFFF);
    chk("after_short1", bus1.o_audio_data, 24'h00FF00);
    send_slot(1'b0, 24'h5A5A5A, 32);
    chk("recover0", bus0.o_audio_data, 24'h5A5A5A);
    chk("recover_v0", v0 - b0, 1);

    // Reset, then stimulus resumes in the middle of a left slot.
    reset = 1'b1;
    #(BIT_T);
    reset = 1'b0;
    b0 = v0; be0 = e0;
    send_slot(1'b0, 24'hFFFFFF, 20);
    send_slot(1'b1, 24'h0A0B0C, 32);
    chk("mid_novld0", v0 - b0, 0);
    chk("mid_data0",  bus0.o_audio_data, 0);
    send_slot(1'b0, 24'h13579B, 32);
    chk("mid_first0", bus0.o_audio_data, 24'h13579B);
    chk("mid_ferr0",  e0 - be0, 0);
    send_slot(1'b1, 24'h0A0B0C, 32);

    // Reset hits 10 bits into a left slot and is held for 2 bit periods.
    fork
      send_slot(1'b0, 24'h555555, 32);
      begin
        #(10 * BIT_T + HALF / 2);
        reset = 1'b1;
        #1;
        chk("arst_data0",  bus0.o_audio_data, 0);
        chk("arst_data1",  bus1.o_audio_data, 0);
        chk("arst_valid0", bus0.o_audio_valid, 0);
        #(2 * BIT_T - 1);
        reset = 1'b0;
      end
    join
    b0 = v0;
    chk("arst_novld0", bus0.o_audio_data, 0);
    send_slot(1'b1, 24'h0F0F0F, 32);
    send_slot(1'b0, 24'h2468AC, 32);
    chk("arst_next0",  bus0.o_audio_data, 24'h2468AC);
    chk("arst_next1",  bus1.o_audio_data, 24'h0F0F0F);
    chk("arst_cnt0",   v0 - b0, 1);

    chk("no_overlap", ovl, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
